msg_load_controller: RTL and testbench



---
 rtl/msg_load_controller.sv | 211 +++++++++++++++++++++
 tb/tb_msg_load_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_load_controller.sv
// rtl/msg_load_controller.sv - frames receiver bytes into particle/map buffer words
// Bytes and flags are edge-detected; every WORD_BYTES accepted bytes produce one buffer write.
module msg_load_controller #(
   parameter int WORD_BYTES           = 4,
   parameter int PARTICLE_FRAME_BYTES = 8,
   parameter int MAP_FRAME_BYTES      = 16,
   parameter int P_ADDR_W = (PARTICLE_FRAME_BYTES / WORD_BYTES > 1) ?
                            $clog2(PARTICLE_FRAME_BYTES / WORD_BYTES) : 1,
   parameter int M_ADDR_W = (MAP_FRAME_BYTES / WORD_BYTES > 1) ?
                            $clog2(MAP_FRAME_BYTES / WORD_BYTES) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [7:0]                msg_in,
   input  logic                      msg_valid,
   input  logic                      particle_flag,
   input  logic                      map_flag,
   input  logic                      core_busy,
   output logic                      part_we,
   output logic [P_ADDR_W-1:0]       part_addr,
   output logic [8*WORD_BYTES-1:0]   part_wdata,
   output logic                      map_we,
   output logic [M_ADDR_W-1:0]       map_addr,
   output logic [8*WORD_BYTES-1:0]   map_wdata,
   output logic                      particle_ready,
   output logic                      map_ready,
   output logic                      frame_error,
   output logic [7:0]                drop_count,
   output logic                      loading
);

   localparam int DATA_W    = 8 * WORD_BYTES;
   localparam int MAX_FRAME = (PARTICLE_FRAME_BYTES > MAP_FRAME_BYTES) ?
                              PARTICLE_FRAME_BYTES : MAP_FRAME_BYTES;
   localparam int CNT_W     = $clog2(MAX_FRAME + 1);
   localparam int LANE_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int WIDX_W    = (P_ADDR_W > M_ADDR_W) ? P_ADDR_W : M_ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_P, S_LOAD_M, S_DONE_P, S_DONE_M, S_DRAIN, S_DROP
   } state_t;

   state_t                state_q, state_d;
   logic                  valid_q, pflag_q, mflag_q;
   logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
   logic [LANE_W-1:0]     lane_q, lane_d;
   logic [WIDX_W-1:0]     word_q, word_d;
   logic [DATA_W-1:0]     pack_q, pack_d;
   logic                  part_we_q, part_we_d, map_we_q, map_we_d;
   logic [P_ADDR_W-1:0]   part_addr_q, part_addr_d;
   logic [M_ADDR_W-1:0]   map_addr_q, map_addr_d;
   logic [DATA_W-1:0]     part_wdata_q, part_wdata_d, map_wdata_q, map_wdata_d;
   logic                  pready_q, pready_d, mready_q, mready_d, ferr_q, ferr_d;
   logic [7:0]            drop_q, drop_d;

   logic byte_acc, p_rise, m_rise, p_fall, m_fall, last_p, last_m;
   logic is_map, act_fall, act_last, take;
   logic [DATA_W-1:0] word_v;

   assign byte_acc = msg_valid & ~valid_q;
   assign p_rise   = particle_flag & ~pflag_q;
   assign m_rise   = map_flag & ~mflag_q;
   assign p_fall   = ~particle_flag & pflag_q;
   assign m_fall   = ~map_flag & mflag_q;
   assign last_p   = (byte_cnt_q == CNT_W'(PARTICLE_FRAME_BYTES - 1));
   assign last_m   = (byte_cnt_q == CNT_W'(MAP_FRAME_BYTES - 1));
   assign is_map   = (state_q == S_LOAD_M);
   assign act_fall = is_map ? m_fall : p_fall;
   assign act_last = is_map ? last_m : last_p;
   // A byte arriving with an early flag fall is dropped unless it completes the frame
   assign take     = byte_acc & (act_last | ~act_fall);
   assign word_v   = (pack_q << 8) | DATA_W'(msg_in);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (p_rise && m_rise)  state_d = S_DRAIN;
            else if (p_rise)       state_d = core_busy ? S_DROP : S_LOAD_P;
            else if (m_rise)       state_d = core_busy ? S_DROP : S_LOAD_M;
         end
         S_LOAD_P: begin
            if (byte_acc && last_p) state_d = S_DONE_P;
            else if (p_fall)        state_d = S_IDLE;
         end
         S_LOAD_M: begin
            if (byte_acc && last_m) state_d = S_DONE_M;
            else if (m_fall)        state_d = S_IDLE;
         end
         S_DONE_P, S_DONE_M: state_d = S_DRAIN;
         S_DRAIN, S_DROP: begin
            if (!particle_flag && !map_flag) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      byte_cnt_d   = byte_cnt_q;
      lane_d       = lane_q;
      word_d       = word_q;
      pack_d       = pack_q;
      part_we_d    = 1'b0;
      map_we_d     = 1'b0;
      part_addr_d  = part_addr_q;
      map_addr_d   = map_addr_q;
      part_wdata_d = part_wdata_q;
      map_wdata_d  = map_wdata_q;
      pready_d     = 1'b0;
      mready_d     = 1'b0;
      ferr_d       = 1'b0;
      drop_d       = drop_q;
      case (state_q)
         S_IDLE: begin
            byte_cnt_d = '0;
            lane_d     = '0;
            word_d     = '0;
            pack_d     = '0;
            if (p_rise && m_rise) ferr_d = 1'b1;
            else if ((p_rise || m_rise) && core_busy && drop_q != 8'hFF)
               drop_d = drop_q + 8'd1;
         end
         S_LOAD_P, S_LOAD_M: begin
            if (take) begin
               pack_d     = word_v;
               byte_cnt_d = byte_cnt_q + CNT_W'(1);
               if (lane_q == LANE_W'(WORD_BYTES - 1)) begin
                  lane_d = '0;
                  word_d = word_q + WIDX_W'(1);
                  if (is_map) begin
                     map_we_d    = 1'b1;
                     map_addr_d  = word_q[M_ADDR_W-1:0];
                     map_wdata_d = word_v;
                  end else begin
                     part_we_d    = 1'b1;
                     part_addr_d  = word_q[P_ADDR_W-1:0];
                     part_wdata_d = word_v;
                  end
               end else begin
                  lane_d = lane_q + LANE_W'(1);
               end
            end
            if (act_fall && !(byte_acc && act_last)) ferr_d = 1'b1;
         end
         S_DONE_P: pready_d = 1'b1;
         S_DONE_M: mready_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q      <= 1'b0;
         pflag_q      <= 1'b0;
         mflag_q      <= 1'b0;
         byte_cnt_q   <= '0;
         lane_q       <= '0;
         word_q       <= '0;
         pack_q       <= '0;
         part_we_q    <= 1'b0;
         map_we_q     <= 1'b0;
         part_addr_q  <= '0;
         map_addr_q   <= '0;
         part_wdata_q <= '0;
         map_wdata_q  <= '0;
         pready_q     <= 1'b0;
         mready_q     <= 1'b0;
         ferr_q       <= 1'b0;
         drop_q       <= '0;
      end else begin
         valid_q      <= msg_valid;
         pflag_q      <= particle_flag;
         mflag_q      <= map_flag;
         byte_cnt_q   <= byte_cnt_d;
         lane_q       <= lane_d;
         word_q       <= word_d;
         pack_q       <= pack_d;
         part_we_q    <= part_we_d;
         map_we_q     <= map_we_d;
         part_addr_q  <= part_addr_d;
         map_addr_q   <= map_addr_d;
         part_wdata_q <= part_wdata_d;
         map_wdata_q  <= map_wdata_d;
         pready_q     <= pready_d;
         mready_q     <= mready_d;
         ferr_q       <= ferr_d;
         drop_q       <= drop_d;
      end
   end

   assign part_we        = part_we_q;
   assign part_addr      = part_addr_q;
   assign part_wdata     = part_wdata_q;
   assign map_we         = map_we_q;
   assign map_addr       = map_addr_q;
   assign map_wdata      = map_wdata_q;
   assign particle_ready = pready_q;
   assign map_ready      = mready_q;
   assign frame_error    = ferr_q;
   assign drop_count     = drop_q;
   assign loading        = (state_q == S_LOAD_P) || (state_q == S_LOAD_M);

endmodule

// File: tb/tb_msg_load_controller.sv
// tb/tb_msg_load_controller.sv - directed scoreboard bench for msg_load_controller
// Expected writes {map_we, part_we, addr, data, cycle} are queued as bytes are driven.
module tb_msg_load_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  msg_in;
   logic        msg_valid, particle_flag, map_flag, core_busy;
   logic        part_we, map_we;
   logic [0:0]  part_addr;
   logic [1:0]  map_addr;
   logic [31:0] part_wdata, map_wdata;
   logic        particle_ready, map_ready, frame_error, loading;
   logic [7:0]  drop_count;

   always #5 clk = ~clk;

   msg_load_controller dut (
      .clk(clk), .reset(reset), .msg_in(msg_in), .msg_valid(msg_valid),
      .particle_flag(particle_flag), .map_flag(map_flag), .core_busy(core_busy),
      .part_we(part_we), .part_addr(part_addr), .part_wdata(part_wdata),
      .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata),
      .particle_ready(particle_ready), .map_ready(map_ready),
      .frame_error(frame_error), .drop_count(drop_count), .loading(loading)
   );

   int tests = 0, fails = 0, cyc = 0;
   int n_part_we, n_map_we, n_pready, n_mready, n_err;
   int pready_cyc, mready_cyc, err_cyc, last_acc, fall_cyc;
   logic [67:0] exp_q[$];
   int          m_cnt;
   bit          m_is_map;
   logic [31:0] m_pack;

   task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_counts();
      n_part_we = 0; n_map_we = 0; n_pready = 0; n_mready = 0; n_err = 0;
      pready_cyc = -1; mready_cyc = -1; err_cyc = -1;
   endtask

   // Advance to the next falling edge and score whatever the DUT presents there
   task automatic step();
      logic [67:0] obs, e;
      @(negedge clk);
      cyc++;
      if (!reset) begin
         if (part_we || map_we) begin
            tests++;
            assert (!(part_we && map_we)) else begin
               fails++;
               $error("FAIL we_exclusive observed=%b%b expected=one-hot", part_we, map_we);
            end
            if (map_we) n_map_we++;
            if (part_we) n_part_we++;
            obs = {map_we, part_we, map_we ? map_addr : {1'b0, part_addr},
                   map_we ? map_wdata : part_wdata, 32'(cyc)};
            tests++;
            assert (exp_q.size() != 0) else begin
               fails++;
               $error("FAIL unexpected_write observed=%0h expected=none", obs);
            end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("write", obs, e);
            end
         end
         if (particle_ready) begin n_pready++; pready_cyc = cyc; end
         if (map_ready)      begin n_mready++; mready_cyc = cyc; end
         if (frame_error)    begin n_err++;    err_cyc = cyc;    end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic start_frame(input bit is_map);
      m_cnt = 0; m_is_map = is_map; m_pack = '0;
      step();
      if (is_map) map_flag = 1'b1; else particle_flag = 1'b1;
   endtask

   task automatic end_frame();
      step();
      particle_flag = 1'b0;
      map_flag = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold, input bit load);
      int frame;
      step();
      msg_in = b;
      msg_valid = 1'b1;
      if (load) begin
         frame = m_is_map ? 16 : 8;
         m_cnt++;
         m_pack = {m_pack[23:0], b};
         if (m_cnt <= frame) begin
            if (m_cnt % 4 == 0)
               exp_q.push_back({m_is_map, !m_is_map, 2'(m_cnt / 4 - 1), m_pack, 32'(cyc + 1)});
            if (m_cnt == frame) last_acc = cyc;
         end
      end
      repeat (hold - 1) step();
      step();
      msg_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check(tag, 68'({part_we, map_we, part_addr, map_addr, part_wdata, map_wdata,
                      particle_ready, map_ready, frame_error, drop_count, loading}), 68'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; msg_in = '0; msg_valid = 1'b0;
      particle_flag = 1'b0; map_flag = 1'b0; core_busy = 1'b0;
      clear_counts();
      idle(3);
      check_reset_values("reset_values");
      reset = 1'b0;
      idle(2);

      // particle frame, single-cycle valid pulses
      clear_counts();
      start_frame(1'b0);
      step();
      check("loading_after_rise", 68'(loading), 68'd1);
      for (int i = 1; i <= 8; i++) send_byte(8'(i), 1, 1'b1);
      idle(4);
      check("p_ready_count", 68'(n_pready), 68'd1);
      check("p_ready_latency", 68'(pready_cyc), 68'(last_acc + 2));
      check("p_writes", 68'(n_part_we), 68'd2);
      end_frame();
      idle(2);
      check("p_idle_loading", 68'(loading), 68'd0);

      // map frame, valid held three cycles per byte
      clear_counts();
      start_frame(1'b1);
      for (int i = 0; i < 16; i++) send_byte(8'hA0 + 8'(i), 3, 1'b1);
      idle(4);
      check("m_writes", 68'(n_map_we), 68'd4);
      check("m_last_word", 68'(map_wdata), 68'h0ACADAEAF);
      check("m_ready_count", 68'(n_mready), 68'd1);
      check("m_ready_latency", 68'(mready_cyc), 68'(last_acc + 2));
      check("m_no_part", 68'(n_part_we + n_pready), 68'd0);
      end_frame();
      idle(2);

      // short particle frame: flag falls after 5 bytes
      clear_counts();
      start_frame(1'b0);
      for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i), 1, 1'b1);
      step();
      particle_flag = 1'b0;
      fall_cyc = cyc;
      idle(4);
      check("short_writes", 68'(n_part_we), 68'd1);
      check("short_err", 68'(n_err), 68'd1);
      check("short_err_cycle", 68'(err_cyc), 68'(fall_cyc + 1));
      check("short_no_ready", 68'(n_pready), 68'd0);
      check("short_idle", 68'(loading), 68'd0);

      // busy drop
      clear_counts();
      core_busy = 1'b1;
      start_frame(1'b1);
      for (int i = 0; i < 16; i++) send_byte(8'h50 + 8'(i), 1, 1'b0);
      end_frame();
      idle(2);
      check("drop_one", 68'(drop_count), 68'd1);
      check("drop_no_writes", 68'(n_map_we + n_part_we + n_mready), 68'd0);
      for (int i = 0; i < 299; i++) begin
         step(); map_flag = 1'b1;
         step(); map_flag = 1'b0;
         step();
      end
      idle(2);
      check("drop_saturate", 68'(drop_count), 68'd255);
      core_busy = 1'b0;

      // overrun: ten bytes into an eight-byte frame
      clear_counts();
      start_frame(1'b0);
      for (int i = 0; i < 10; i++) send_byte(8'h31 + 8'(i), 1, 1'b1);
      idle(3);
      check("over_writes", 68'(n_part_we), 68'd2);
      check("over_ready", 68'(n_pready), 68'd1);
      end_frame();
      idle(2);

      // both flags rise together
      clear_counts();
      step();
      particle_flag = 1'b1;
      map_flag = 1'b1;
      fall_cyc = cyc;
      for (int i = 0; i < 4; i++) send_byte(8'h70 + 8'(i), 1, 1'b0);
      end_frame();
      idle(2);
      check("both_err", 68'(n_err), 68'd1);
      check("both_err_cycle", 68'(err_cyc), 68'(fall_cyc + 1));
      check("both_no_writes", 68'(n_part_we + n_map_we), 68'd0);

      // reset mid map frame, then a clean particle frame
      clear_counts();
      start_frame(1'b1);
      for (int i = 0; i < 3; i++) send_byte(8'h90 + 8'(i), 1, 1'b1);
      step();
      #2 reset = 1'b1;
      #1 check_reset_values("reset_mid_frame");
      map_flag = 1'b0;
      idle(2);
      reset = 1'b0;
      idle(2);
      check_reset_values("reset_released");
      start_frame(1'b0);
      for (int i = 0; i < 8; i++) send_byte(8'h21 + 8'(i), 1, 1'b1);
      idle(4);
      check("post_reset_writes", 68'(n_part_we), 68'd2);
      check("post_reset_ready", 68'(n_pready), 68'd1);
      check("post_reset_no_map", 68'(n_map_we + n_mready), 68'd0);
      end_frame();
      idle(2);
      check("queue_empty", 68'(exp_q.size()), 68'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
